// File: rtl/fp_cvt_d_seq.sv
// Multi-cycle integer-to-double converter (FCVT.D.W/WU/L/LU) with a valid/ready request and result handshake.
// Define FP_CVT_FAST_NORM_EN to normalize in one step during PREP. Otherwise NORM shifts iteratively by NORM_STEP.
module fp_cvt_d_seq #(
    parameter int unsigned NORM_STEP = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_op,
    input  logic [63:0] in_rs1,
    input  logic [2:0]  in_rm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_d,
    output logic [4:0]  out_fflags
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_PREP  = 3'd1;
    localparam logic [2:0] ST_NORM  = 3'd2;
    localparam logic [2:0] ST_ROUND = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [1:0]  OP_W   = 2'd0;
    localparam logic [1:0]  OP_WU  = 2'd1;
    localparam logic [1:0]  OP_L   = 2'd2;
    localparam logic [10:0] EXP_TOP = 11'd1086;  // biased exponent when bit 63 is the leading one

    logic [2:0]  state_q,      state_d;
    logic [1:0]  op_q,         op_d;
    logic [63:0] rs1_q,        rs1_d;
    logic [2:0]  rm_q,         rm_d;
    logic        sign_q,       sign_d;
    logic [63:0] mag_q,        mag_d;
    logic [10:0] exp_q,        exp_d;
    logic [63:0] out_d_q,      out_d_d;
    logic [4:0]  out_fflags_q, out_fflags_d;

    logic [63:0] prep_src;
    logic        prep_sign;
    logic [63:0] prep_mag;
    logic [51:0] rnd_man;
    logic        rnd_guard;
    logic        rnd_sticky;
    logic        rnd_nx;
    logic        rnd_inc;
    logic [52:0] rnd_sum;

`ifdef FP_CVT_FAST_NORM_EN
    logic [6:0] prep_lzc;

    function automatic logic [6:0] lzc64(input logic [63:0] v);
        logic [6:0] n;
        logic       found;
        n     = 7'd64;
        found = 1'b0;
        for (int i = 63; i >= 0; i--) begin
            if (!found && v[i]) begin
                n     = 7'(63 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

    assign prep_lzc = lzc64(prep_mag);
`endif

    always_comb begin
        case (op_q)
            OP_W:    prep_src = {{32{rs1_q[31]}}, rs1_q[31:0]};
            OP_WU:   prep_src = {32'd0, rs1_q[31:0]};
            default: prep_src = rs1_q;
        endcase
        prep_sign = ((op_q == OP_W) || (op_q == OP_L)) && prep_src[63];
        prep_mag  = prep_sign ? (~prep_src + 64'd1) : prep_src;
    end

    always_comb begin
        rnd_man    = mag_q[62:11];
        rnd_guard  = mag_q[10];
        rnd_sticky = |mag_q[9:0];
        rnd_nx     = rnd_guard | rnd_sticky;
        case (rm_q)
            3'd1:    rnd_inc = 1'b0;
            3'd2:    rnd_inc = sign_q & rnd_nx;
            3'd3:    rnd_inc = ~sign_q & rnd_nx;
            3'd4:    rnd_inc = rnd_guard;
            default: rnd_inc = rnd_guard & (rnd_sticky | rnd_man[0]);
        endcase
        rnd_sum = {1'b0, rnd_man} + {52'd0, rnd_inc};
    end

    // NOTE: every *_d starts from its *_q value so no path through the case leaves a latch.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        rs1_d        = rs1_q;
        rm_d         = rm_q;
        sign_d       = sign_q;
        mag_d        = mag_q;
        exp_d        = exp_q;
        out_d_d      = out_d_q;
        out_fflags_d = out_fflags_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    op_d    = in_op;
                    rs1_d   = in_rs1;
                    rm_d    = in_rm;
                    state_d = ST_PREP;
                end
            end
            ST_PREP: begin
                sign_d = prep_sign;
                mag_d  = prep_mag;
                exp_d  = EXP_TOP;
                if (prep_mag == 64'd0) begin
                    out_d_d      = 64'd0;
                    out_fflags_d = 5'd0;
                    state_d      = ST_DONE;
                end else begin
`ifdef FP_CVT_FAST_NORM_EN
                    mag_d   = prep_mag << prep_lzc[5:0];
                    exp_d   = EXP_TOP - {4'd0, prep_lzc};
                    state_d = ST_ROUND;
`else
                    state_d = ST_NORM;
`endif
                end
            end
            ST_NORM: begin
                if (mag_q[63]) begin
                    state_d = ST_ROUND;
                end else if (mag_q[63:64-NORM_STEP] == '0) begin
                    mag_d = mag_q << NORM_STEP;
                    exp_d = exp_q - 11'(NORM_STEP);
                end else begin
                    mag_d = mag_q << 1;
                    exp_d = exp_q - 11'd1;
                end
            end
            ST_ROUND: begin
                // A carry out of the mantissa means the value rounded up to the next power of two.
                if (rnd_sum[52]) begin
                    out_d_d = {sign_q, exp_q + 11'd1, 52'd0};
                end else begin
                    out_d_d = {sign_q, exp_q, rnd_sum[51:0]};
                end
                out_fflags_d = {4'd0, rnd_nx};
                state_d      = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (flush) state_d = ST_IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            op_q         <= 2'd0;
            rs1_q        <= 64'd0;
            rm_q         <= 3'd0;
            sign_q       <= 1'b0;
            mag_q        <= 64'd0;
            exp_q        <= 11'd0;
            out_d_q      <= 64'd0;
            out_fflags_q <= 5'd0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            rs1_q        <= rs1_d;
            rm_q         <= rm_d;
            sign_q       <= sign_d;
            mag_q        <= mag_d;
            exp_q        <= exp_d;
            out_d_q      <= out_d_d;
            out_fflags_q <= out_fflags_d;
        end
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign out_valid  = (state_q == ST_DONE);
    assign out_d      = out_d_q;
    assign out_fflags = out_fflags_q;

endmodule

// File: tb/tb_fp_cvt_d_seq.sv
// Self-checking bench for fp_cvt_d_seq: directed vectors, random requests against an arithmetic model, handshake/flush/reset sequences.
module tb_fp_cvt_d_seq;

    localparam int NS = 4;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [63:0] in_rs1;
    logic [2:0]  in_rm;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_d;
    logic [4:0]  out_fflags;

    int checks;
    int failures;

    fp_cvt_d_seq #(.NORM_STEP(NS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rs1     (in_rs1),
        .in_rm      (in_rm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_d      (out_d),
        .out_fflags (out_fflags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [63:0] rs1;
        logic [2:0]  rm;
        logic [63:0] exp_d;
        logic        exp_nx;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, got, want);
        end
    endtask

    // Magnitude of the operand as a signed or unsigned integer of the selected width.
    function automatic logic [63:0] ref_mag(input logic [1:0] op, input logic [63:0] rs1, output logic s);
        longint signed sv;
        case (op)
            2'd0: begin sv = longint'(signed'(rs1[31:0])); s = sv < 0; return s ? 64'(-sv) : 64'(sv); end
            2'd1: begin s = 1'b0; return {32'd0, rs1[31:0]}; end
            2'd2: begin sv = signed'(rs1); s = sv < 0; return s ? 64'(-sv) : 64'(sv); end
            default: begin s = 1'b0; return rs1; end
        endcase
    endfunction

    function automatic int msb_pos(input logic [63:0] v);
        int p;
        p = -1;
        for (int i = 0; i < 64; i++) if (v[i]) p = i;
        return p;
    endfunction

    // Value = mag = 2^p * 1.f; keep 53 significant bits and round the discarded remainder.
    task automatic ref_conv(input logic [1:0] op, input logic [63:0] rs1, input logic [2:0] rm,
                            output logic [63:0] d, output logic nx);
        logic        s;
        logic [63:0] mag, trunc, rem, half;
        logic [51:0] man;
        logic        inc;
        int          p, sh, e;
        mag = ref_mag(op, rs1, s);
        nx  = 1'b0;
        if (mag == 64'd0) begin
            d = 64'd0;
            return;
        end
        p = msb_pos(mag);
        e = 1023 + p;
        if (p <= 52) begin
            man = 52'(mag << (52 - p));
        end else begin
            sh    = p - 52;
            trunc = mag >> sh;
            rem   = mag & ((64'd1 << sh) - 64'd1);
            half  = 64'd1 << (sh - 1);
            nx    = (rem != 64'd0);
            case (rm)
                3'd1:    inc = 1'b0;
                3'd2:    inc = s && nx;
                3'd3:    inc = !s && nx;
                3'd4:    inc = (rem >= half);
                default: inc = (rem > half) || ((rem == half) && trunc[0]);
            endcase
            trunc = trunc + 64'(inc);
            if (trunc == (64'd1 << 53)) begin
                e   = e + 1;
                man = 52'd0;
            end else begin
                man = trunc[51:0];
            end
        end
        d = {s, 11'(e), man};
    endtask

    function automatic int ref_lat(input logic [1:0] op, input logic [63:0] rs1);
        logic        s;
        logic [63:0] mag;
        int          lz;
        mag = ref_mag(op, rs1, s);
        if (mag == 64'd0) return 2;
`ifdef FP_CVT_FAST_NORM_EN
        return 3;
`else
        lz = 63 - msb_pos(mag);
        return (lz / NS) + (lz % NS) + 4;
`endif
    endfunction

    // Drive one request; returns at the falling edge of cycle T+1.
    task automatic send(input logic [1:0] op, input logic [63:0] rs1, input logic [2:0] rm);
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = op;
        in_rs1   = rs1;
        in_rm    = rm;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Count cycles after T until out_valid; -1 on timeout.
    task automatic wait_valid(output int lat);
        int n;
        n = 1;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        lat = out_valid ? n : -1;
    endtask

    task automatic accept(input string name);
        check({name, "_in_ready_in_done"}, 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({name, "_idle_after_accept"}, {62'd0, in_ready, out_valid}, 64'd2);
    endtask

    task automatic run_and_check(input string name, input logic [1:0] op, input logic [63:0] rs1,
                                 input logic [2:0] rm, input logic [63:0] exp_d, input logic exp_nx);
        int lat;
        send(op, rs1, rm);
        wait_valid(lat);
        check({name, "_latency"}, 64'(lat), 64'(ref_lat(op, rs1)));
        check({name, "_d"}, out_d, exp_d);
        check({name, "_fflags"}, 64'(out_fflags), {59'd0, 4'd0, exp_nx});
        accept(name);
    endtask

    initial begin
        logic [63:0] md;
        logic        mnx;
        logic [63:0] rs1;
        logic [1:0]  op;
        logic [2:0]  rm;
        logic [63:0] held_d;
        logic [4:0]  held_f;
        logic        seen;
        int          lat;

        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 2'd0;
        in_rs1    = 64'd0;
        in_rm     = 3'd0;
        out_ready = 1'b0;

        vecs[0]  = '{2'd0, 64'h0000_0000_FFFF_FFFF, 3'd0, 64'hBFF0_0000_0000_0000, 1'b0};
        vecs[1]  = '{2'd1, 64'h0000_0000_FFFF_FFFF, 3'd0, 64'h41EF_FFFF_FFE0_0000, 1'b0};
        vecs[2]  = '{2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 3'd0, 64'h43F0_0000_0000_0000, 1'b1};
        vecs[3]  = '{2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 64'h43EF_FFFF_FFFF_FFFF, 1'b1};
        vecs[4]  = '{2'd2, 64'h8000_0000_0000_0000, 3'd0, 64'hC3E0_0000_0000_0000, 1'b0};
        vecs[5]  = '{2'd2, 64'h0000_0000_0000_0000, 3'd0, 64'h0000_0000_0000_0000, 1'b0};
        vecs[6]  = '{2'd2, 64'h0000_0000_0000_0001, 3'd0, 64'h3FF0_0000_0000_0000, 1'b0};
        vecs[7]  = '{2'd2, 64'hFFFF_FFFF_FFFF_FFFF, 3'd0, 64'hBFF0_0000_0000_0000, 1'b0};
        vecs[8]  = '{2'd3, 64'h8000_0000_0000_0400, 3'd0, 64'h43E0_0000_0000_0000, 1'b1};
        vecs[9]  = '{2'd3, 64'h8000_0000_0000_0400, 3'd4, 64'h43E0_0000_0000_0001, 1'b1};
        vecs[10] = '{2'd3, 64'h8000_0000_0000_0400, 3'd3, 64'h43E0_0000_0000_0001, 1'b1};
        vecs[11] = '{2'd3, 64'h8000_0000_0000_0400, 3'd2, 64'h43E0_0000_0000_0000, 1'b1};
        vecs[12] = '{2'd2, 64'hBFFF_FFFF_FFFF_FFFF, 3'd2, 64'hC3D0_0000_0000_0001, 1'b1};
        vecs[13] = '{2'd2, 64'hBFFF_FFFF_FFFF_FFFF, 3'd3, 64'hC3D0_0000_0000_0000, 1'b1};
        vecs[14] = '{2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 3'd5, 64'h43F0_0000_0000_0000, 1'b1};
        vecs[15] = '{2'd1, 64'hDEAD_BEEF_0000_0001, 3'd0, 64'h3FF0_0000_0000_0000, 1'b0};

        repeat (3) @(negedge clk);
        check("reset_ready_valid", {62'd0, in_ready, out_valid}, 64'd2);
        check("reset_out_d", out_d, 64'd0);
        check("reset_fflags", 64'(out_fflags), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            run_and_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].rs1, vecs[i].rm,
                          vecs[i].exp_d, vecs[i].exp_nx);
        end

        for (int i = 0; i < 30; i++) begin
            rs1 = {$urandom(), $urandom()};
            rs1 = rs1 >> $urandom_range(0, 63);
            op  = 2'($urandom_range(0, 3));
            rm  = 3'($urandom_range(0, 7));
            ref_conv(op, rs1, rm, md, mnx);
            run_and_check($sformatf("rand%0d", i), op, rs1, rm, md, mnx);
        end

        // WU 1: longest iterative normalization path.
        send(2'd1, 64'd1, 3'd0);
        wait_valid(lat);
`ifdef FP_CVT_FAST_NORM_EN
        check("wu1_latency", 64'(lat), 64'd3);
`else
        check("wu1_latency", 64'(lat), 64'd22);
`endif
        check("wu1_d", out_d, 64'h3FF0_0000_0000_0000);
        accept("wu1");

        // Result must hold steady while the consumer stalls.
        send(2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 3'd0);
        wait_valid(lat);
        held_d = out_d;
        held_f = out_fflags;
        check("stall_first_d", held_d, 64'h43F0_0000_0000_0000);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("stall%0d_valid", i), {62'd0, in_ready, out_valid}, 64'd1);
            check($sformatf("stall%0d_d", i), out_d, held_d);
            check($sformatf("stall%0d_fflags", i), 64'(out_fflags), 64'(held_f));
        end
        accept("stall");

        // Flush mid-NORM discards the request.
        send(2'd1, 64'd1, 3'd0);
        repeat (3) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_idle", {62'd0, in_ready, out_valid}, 64'd2);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("flush_no_result", 64'(seen), 64'd0);

        // Flush wins over a same-cycle request.
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = 2'd2;
        in_rs1   = 64'd5;
        flush    = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        check("flush_blocks_accept", 64'(in_ready), 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("flush_accept_no_result", 64'(seen), 64'd0);

        // Asynchronous reset mid-NORM, with a nonzero result still held from before.
        run_and_check("pre_reset", 2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 64'h43EF_FFFF_FFFF_FFFF, 1'b1);
        send(2'd1, 64'd1, 3'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_ready_valid", {62'd0, in_ready, out_valid}, 64'd2);
        check("rst_mid_out_d", out_d, 64'd0);
        check("rst_mid_fflags", 64'(out_fflags), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("rst_no_result", 64'(seen), 64'd0);

        run_and_check("post_reset", 2'd0, 64'h0000_0000_8000_0000, 3'd0, 64'hC1E0_0000_0000_0000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp_cvt_d_seq.md
# fp_cvt_d_seq

Multi-cycle sequencer for integer-to-double conversion (FCVT.D.W / .WU / .L / .LU) in the RISC D-extension ALU.

- Accepts one request at a time over a valid/ready handshake.
- Forms the sign/magnitude, normalizes the operand (iteratively or in one step), then rounds to 52-bit mantissa per `rm`.
- Returns the IEEE 754 result with fflags.
- Sits between the D-ALU issue stage and the FP writeback mux.

## Interface
- `NORM_STEP`, default 4: bits shifted per iterative NORM cycle when the top `NORM_STEP` bits are zero; legal values are 2, 4 and 8.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous abort; drops any in-flight operation.
- `in_valid` in 1: request valid.
- `in_ready` out 1: high only in IDLE.
- `in_op` in 2: operation select; 0=W, 1=WU, 2=L, 3=LU.
- `in_rs1` in 64: integer source; W/WU use bits [31:0].
- `in_rm` in 3: rounding mode; 0=RNE, 1=RTZ, 2=RDN, 3=RUP, 4=RMM, 5–7 treated as RNE.
- `out_valid` out 1: result valid; held until accepted.
- `out_ready` in 1: consumer accepts the result.
- `out_d` out 64: IEEE 754 double result.
- `out_fflags` out 5: {NV,DZ,OF,UF,NX}; only NX can ever be 1.

## Operation
- States: IDLE, PREP, NORM, ROUND, DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`: capture op, rs1, rm, then go to PREP.
- **PREP**
  - src: W = sign-extend rs1[31:0]; WU = zero-extend rs1[31:0]; L/LU = rs1.
  - sign = (op W or L) && src[63].
  - mag = sign ? (~src + 1) : src, as 64-bit unsigned; −2^63 gives magnitude 0x8000000000000000.
  - exp = 1086, 11 bits.
  - If mag==0: result = +0, go to DONE. Otherwise go to NORM.
- **NORM**, one decision per cycle:
  - mag[63]=1: go to ROUND.
  - Else if mag[63:64−NORM_STEP]==0: mag <<= NORM_STEP, exp −= NORM_STEP.
  - Else: mag <<= 1, exp −= 1.
- **ROUND**
  - Fields: man = mag[62:11], guard = mag[10], sticky = |mag[9:0], NX = guard|sticky.
  - RNE increments if guard && (sticky || man[0]).
  - RTZ never increments.
  - RDN increments if sign && NX.
  - RUP increments if !sign && NX.
  - RMM increments if guard.
  - If man overflows on increment: man = 0, exp += 1.
  - Result = {sign, exp, man}. Go to DONE.
- **DONE**
  - `out_valid`=1; `out_d` and `out_fflags` stay stable.
  - On `out_ready`: go to IDLE.
- W and WU are always exact (NX=0), and overflow is impossible.
- `flush` sends every state to IDLE next cycle and clears `out_valid`. It takes priority over `out_ready` and over an `in_valid` acceptance in the same cycle.
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `out_d`=0, `out_fflags`=0. Asserting reset mid-operation discards the request.

## Timing
- Request accepted at cycle T. PREP runs at T+1.
- Iterative mode:
  - Takes k+1 NORM cycles, where k is the number of shift steps.
  - ROUND follows the last NORM cycle; `out_valid` rises the cycle after ROUND.
  - Example: WU 1 with NORM_STEP=4 gives k=18 (15 shifts of 4, then 3 of 1). NORM runs T+2..T+20, ROUND T+21, `out_valid` at T+22.
- Zero input: `out_valid` at T+2.
- Already-normalized input (bit 63 set after PREP): `out_valid` at T+4.
- Outputs are registered. A result accepted at cycle R allows the next request to be accepted at R+1 (IDLE), never at R.

## Configuration
- `FP_CVT_FAST_NORM_EN` defined:
  - PREP computes a full 64-bit leading-zero count and applies the shift and exponent adjust in the same cycle.
  - PREP goes directly to ROUND; the NORM state and `NORM_STEP` are unused.
  - Nonzero latency is fixed: `out_valid` at T+3.
- Undefined: iterative NORM as described above.
- Results and fflags are bit-identical in both builds.

## Test plan
- W, rs1=0x00000000FFFFFFFF, rm=RNE -> `out_d`=0xBFF0000000000000, NX=0.
- WU, rs1=0xFFFFFFFF -> `out_d`=0x41EFFFFFFFE00000, NX=0.
- LU, rs1=0xFFFFFFFFFFFFFFFF:
  - RNE -> 0x43F0000000000000, NX=1.
  - RTZ -> 0x43EFFFFFFFFFFFFF, NX=1.
- L, rs1=0x8000000000000000 -> 0xC3E0000000000000, NX=0.
- L, rs1=0 -> `out_d`=0, `out_valid` at T+2.
- Latency and flush:
  - WU 1 with NORM_STEP=4 (macro undefined) -> `out_valid` at T+22.
  - Hold `out_ready`=0 for 5 cycles -> outputs stable.
  - Assert `flush` during NORM -> IDLE next cycle, `out_valid` stays 0.
  - Deassert `rst_n` mid-NORM -> immediate IDLE with reset values.
